// File: rtl/bit_iter.sv
// bit_iter: iterates over the set bits of a WIDTH-bit vector and emits one
// absolute bit index per output beat, LSB-first or MSB-first per vector.
// An all-zero vector produces a single "empty" beat.
// Optional feature: define BIT_ITER_FLUSH_EN to add the flush_i port, which
// drops the vector currently being iterated.
//
// state | meaning
// IDLE  | no vector held, ready for a new one
// BUSY  | emitting indices of the set bits still pending in pend_q
// EMPTY | emitting the single beat for an all-zero vector
module bit_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef BIT_ITER_FLUSH_EN
  input  logic                 flush_i,
`endif
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  input  logic                 in_mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] out_idx_o,
  output logic                 out_last_o,
  output logic                 out_empty_o
);

  typedef enum logic [1:0] {IDLE, BUSY, EMPTY} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pend_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] lo_idx, hi_idx, sel_idx;
  logic                 one_set;
  logic                 hs, accept, flush;

`ifdef BIT_ITER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Find-first-set from both ends; the later loop iteration wins.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) lo_idx = CNT_WIDTH'(i);
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (pend_q[j]) hi_idx = CNT_WIDTH'(j);
    end
  end

  assign sel_idx = mode_q ? hi_idx : lo_idx;
  assign one_set = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a vector accepted on the last beat loads directly.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = (in_data_i != '0) ? BUSY : EMPTY;
    end else if (hs && out_last_o) begin
      state_d = IDLE;
    end
  end

  // Outputs; everything is held low while reset is asserted.
  always_comb begin
    out_valid_o = 1'b0;
    out_idx_o   = '0;
    out_last_o  = 1'b0;
    out_empty_o = 1'b0;
    in_ready_o  = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          in_ready_o = !flush;
        end
        BUSY: begin
          out_valid_o = 1'b1;
          out_idx_o   = sel_idx;
          out_last_o  = one_set;
          in_ready_o  = !flush && one_set && out_ready_i;
        end
        EMPTY: begin
          out_valid_o = 1'b1;
          out_last_o  = 1'b1;
          out_empty_o = 1'b1;
          in_ready_o  = !flush && out_ready_i;
        end
        default: ;
      endcase
    end
  end

  assign hs     = out_valid_o && out_ready_i;
  assign accept = in_valid_i && in_ready_o;

  // Pending-bit bitmap and iteration order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      mode_q <= 1'b0;
    end else if (flush) begin
      pend_q <= '0;
    end else if (accept) begin
      pend_q <= in_data_i;
      mode_q <= in_mode_i;
    end else if (hs && (state_q == BUSY)) begin
      pend_q[sel_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_iter.sv
// tb_bit_iter: directed and randomized checks of bit_iter (WIDTH=8) against a
// queue-of-expected-beats reference model.
module tb_bit_iter;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_mode;
  logic          out_valid, out_ready, out_last, out_empty, flush;
  logic [W-1:0]  in_data;
  logic [CW-1:0] out_idx;

  always #5 clk = ~clk;

  bit_iter #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
`ifdef BIT_ITER_FLUSH_EN
    .flush_i     (flush),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_mode_i   (in_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .out_empty_o (out_empty)
  );

  typedef struct {
    int idx;
    bit last;
    bit empty;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    last_acc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected beats of one vector: set-bit positions in the requested order.
  function automatic void push_vec(logic [W-1:0] d, bit m);
    beat_t b;
    int    ids[$];
    if (m) begin
      for (int i = W - 1; i >= 0; i--) if (d[i]) ids.push_back(i);
    end else begin
      for (int i = 0; i < W; i++) if (d[i]) ids.push_back(i);
    end
    if (ids.size() == 0) begin
      b.idx = 0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < ids.size(); k++) begin
        b.idx = ids[k]; b.last = (k == ids.size() - 1); b.empty = 1'b0;
        exp_q.push_back(b);
      end
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, update model.
  task automatic step(bit r, bit v, logic [W-1:0] d, bit m, bit ordy, bit f);
    beat_t b;
    bit    e_valid, e_rdy, hs, acc;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_mode = m; out_ready = ordy; flush = f;
    #1;
    e_valid = !r && (exp_q.size() > 0);
    b.idx = 0; b.last = 1'b0; b.empty = 1'b0;
    if (e_valid) b = exp_q[0];
    e_rdy = !r && !f && ((exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_idx",   32'(out_idx),   32'(b.idx));
    chk("out_last",  32'(out_last),  32'(b.last));
    chk("out_empty", 32'(out_empty), 32'(b.empty));
    chk("in_ready",  32'(in_ready),  32'(e_rdy));
    hs  = e_valid && ordy;
    acc = e_rdy && v;
    if (r || f) begin
      exp_q.delete();
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (acc) push_vec(d, m);
    end
    last_acc = acc;
  endtask

  task automatic send(logic [W-1:0] d, bit m);
    for (int t = 0; t < 20; t++) begin
      step(1'b0, 1'b1, d, m, 1'b1, 1'b0);
      if (last_acc) return;
    end
    n_vec++;
    n_err++;
    $error("FAIL send_timeout observed=not_accepted expected=accepted data=%0h", d);
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, 1'b0, W'($urandom), 1'b0, 1'b1, 1'b0);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL drain_timeout observed=%0d expected=0 beats left", exp_q.size());
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bit          r, v, m, o, f;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b0; flush = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    send(8'b1010_0100, 1'b0); drain();
    send(8'b1010_0100, 1'b1); drain();
    send(8'h00, 1'b0);        drain();

    send(8'h81, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain();

    send(8'h10, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    chk("b2b_accept", 32'(last_acc), 32'(1));
    drain();

    send(8'hFF, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    send(8'h02, 1'b0); drain();

`ifdef BIT_ITER_FLUSH_EN
    send(8'hFF, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    send(8'h02, 1'b0); drain();
`endif

    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) == 0);
      v = $urandom_range(0, 1) == 1;
      m = $urandom_range(0, 1) == 1;
      o = $urandom_range(0, 3) != 0;
      f = 1'b0;
`ifdef BIT_ITER_FLUSH_EN
      f = ($urandom_range(0, 49) == 0);
`endif
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = W'(1) << $urandom_range(0, W - 1);
        default: d = W'($urandom);
      endcase
      step(r, v, d, m, o, f);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
